// File: rtl/regfile_ctrl_pkg.sv
// regfile_ctrl_pkg
// Shared definitions for the register-file controller: default widths,
// opcode encodings and the FSM state encoding.
package regfile_ctrl_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MOV = 3'b101;
    localparam logic [2:0] OP_LDI = 3'b110;
    localparam logic [2:0] OP_SHL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_e;

endpackage

// File: rtl/regfile_alu.sv
// regfile_alu
// Combinational ALU for the register-file controller.
// Ports:
//   op      in   3-bit opcode (see regfile_ctrl_pkg)
//   a, b    in   operands
//   imm     in   immediate (LDI)
//   result  out  result modulo 2^DW
//   carry   out  ADD carry-out, SUB borrow, SHL shifted-out bit, else 0
module regfile_alu
    import regfile_ctrl_pkg::*;
#(
    parameter int DW = DATA_WIDTH
) (
    input  logic [2:0]    op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [DW-1:0] imm,
    output logic [DW-1:0] result,
    output logic          carry
);

    // One extra bit: top bit of sum is carry, top bit of difference is borrow.
    logic [DW:0] sum;
    logic [DW:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_ADD: begin result = sum[DW-1:0];  carry = sum[DW];  end
            OP_SUB: begin result = diff[DW-1:0]; carry = diff[DW]; end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_MOV: result = a;
            OP_LDI: result = imm;
            OP_SHL: begin result = {a[DW-2:0], 1'b0}; carry = a[DW-1]; end
            default: ;
        endcase
    end

endmodule

// File: rtl/register_file.sv
// register_file
// 16 x 8-bit register file with two combinational read ports and one
// synchronous write port. Contents are not reset: a controller reset must
// never disturb stored values.
// Ports:
//   clk                      rising-edge clock
//   A_sel, B_sel      in     read indices
//   A, B              out    read data (combinational)
//   replaceSel        in     write index
//   replaceData       in     write data
//   replaceEn         in     write strobe
module register_file
    import regfile_ctrl_pkg::*;
#(
    parameter int DW = DATA_WIDTH,
    parameter int AW = ADDR_WIDTH
) (
    input  logic          clk,
    input  logic [AW-1:0] A_sel,
    input  logic [AW-1:0] B_sel,
    output logic [DW-1:0] A,
    output logic [DW-1:0] B,
    input  logic [AW-1:0] replaceSel,
    input  logic [DW-1:0] replaceData,
    input  logic          replaceEn
);

    localparam int NREG = 1 << AW;

    logic [DW-1:0] mem_q [NREG];
    logic [DW-1:0] mem_d [NREG];

    always_comb begin
        mem_d = mem_q;
        if (replaceEn) mem_d[replaceSel] = replaceData;
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign A = mem_q[A_sel];
    assign B = mem_q[B_sel];

endmodule

// File: rtl/regfile_controller.sv
// regfile_controller
// Accepts one register-to-register instruction per handshake, reads two
// operands from register_file, runs the ALU and writes the result back.
// Fixed 4-cycle sequence IDLE -> READ -> EXEC -> WB.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   instr_valid/instr_ready        instruction handshake
//   op, rd, ra, rb, imm            instruction fields
//   A_sel, B_sel / A, B            register_file read ports
//   replaceSel/Data/En             register_file write port
//   done                           pulse coincident with the write
//   result, carry, zero            last computed result and flags
module regfile_controller
    import regfile_ctrl_pkg::*;
#(
    parameter int DW = DATA_WIDTH,
    parameter int AW = ADDR_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [2:0]    op,
    input  logic [AW-1:0] rd,
    input  logic [AW-1:0] ra,
    input  logic [AW-1:0] rb,
    input  logic [DW-1:0] imm,
    output logic [AW-1:0] A_sel,
    output logic [AW-1:0] B_sel,
    input  logic [DW-1:0] A,
    input  logic [DW-1:0] B,
    output logic [AW-1:0] replaceSel,
    output logic [DW-1:0] replaceData,
    output logic          replaceEn,
    output logic          done,
    output logic [DW-1:0] result,
    output logic          carry,
    output logic          zero
);

    state_e        state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [DW-1:0] imm_q, imm_d;
    logic [AW-1:0] a_sel_q, a_sel_d;
    logic [AW-1:0] b_sel_q, b_sel_d;
    logic [DW-1:0] a_q, a_d;
    logic [DW-1:0] b_q, b_d;
    logic [DW-1:0] result_q, result_d;
    logic          carry_q, carry_d;
    logic          zero_q, zero_d;
    logic [AW-1:0] wsel_q, wsel_d;
    logic [DW-1:0] wdata_q, wdata_d;

    logic [DW-1:0] alu_result;
    logic          alu_carry;

    regfile_alu #(.DW(DW)) u_alu (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .imm    (imm_q),
        .result (alu_result),
        .carry  (alu_carry)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        imm_d    = imm_q;
        a_sel_d  = a_sel_q;
        b_sel_d  = b_sel_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        wsel_d   = wsel_q;
        wdata_d  = wdata_q;
        case (state_q)
            ST_IDLE: begin
                // Ready is implied in IDLE; rst overrides in the register.
                if (instr_valid) begin
                    op_d    = op;
                    rd_d    = rd;
                    imm_d   = imm;
                    a_sel_d = ra;
                    b_sel_d = rb;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                a_d     = A;
                b_d     = B;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                result_d = alu_result;
                carry_d  = alu_carry;
                zero_d   = (alu_result == '0);
                wsel_d   = rd_q;
                wdata_d  = alu_result;
                state_d  = ST_WB;
            end
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            rd_q     <= '0;
            imm_q    <= '0;
            a_sel_q  <= '0;
            b_sel_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            wsel_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            imm_q    <= imm_d;
            a_sel_q  <= a_sel_d;
            b_sel_q  <= b_sel_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            wsel_q   <= wsel_d;
            wdata_q  <= wdata_d;
        end
    end

    // Gated by rst so a reset landing in WB cannot commit a partial write,
    // and so ready is low for the whole reset interval.
    assign instr_ready = (state_q == ST_IDLE) && !rst;
    assign replaceEn   = (state_q == ST_WB) && !rst;
    assign done        = replaceEn;

    assign A_sel       = a_sel_q;
    assign B_sel       = b_sel_q;
    assign replaceSel  = wsel_q;
    assign replaceData = wdata_q;
    assign result      = result_q;
    assign carry       = carry_q;
    assign zero        = zero_q;

endmodule

// File: tb/tb_regfile_controller.sv
module tb_regfile_controller;
    import regfile_ctrl_pkg::*;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          instr_valid;
    logic          instr_ready;
    logic [2:0]    op;
    logic [AW-1:0] rd, ra, rb;
    logic [DW-1:0] imm;
    logic [AW-1:0] A_sel, B_sel;
    logic [DW-1:0] A, B;
    logic [AW-1:0] replaceSel;
    logic [DW-1:0] replaceData;
    logic          replaceEn;
    logic          done;
    logic [DW-1:0] result;
    logic          carry, zero;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regfile_controller #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .op(op), .rd(rd), .ra(ra), .rb(rb), .imm(imm),
        .A_sel(A_sel), .B_sel(B_sel), .A(A), .B(B),
        .replaceSel(replaceSel), .replaceData(replaceData), .replaceEn(replaceEn),
        .done(done), .result(result), .carry(carry), .zero(zero)
    );

    register_file #(.DW(DW), .AW(AW)) u_rf (
        .clk(clk), .A_sel(A_sel), .B_sel(B_sel), .A(A), .B(B),
        .replaceSel(replaceSel), .replaceData(replaceData), .replaceEn(replaceEn)
    );

    typedef struct {
        logic [2:0]    op;
        logic [AW-1:0] rd, ra, rb;
        logic [DW-1:0] imm;
        logic [DW-1:0] exp_data;
        logic          exp_c, exp_z;
    } vec_t;

    localparam int NV = 13;
    vec_t vt [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] o, input logic [AW-1:0] d, input logic [AW-1:0] a,
                         input logic [AW-1:0] b, input logic [DW-1:0] im);
        op = o; rd = d; ra = a; rb = b; imm = im;
    endtask

    task automatic wait_ready(input string name);
        int budget = 0;
        @(negedge clk);
        while (!instr_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (!instr_ready) chk({name, "_ready_timeout"}, 0, 1);
    endtask

    // Issue one instruction and check the full 4-cycle sequence.
    task automatic run(input string name, input vec_t v);
        wait_ready(name);
        drive(v.op, v.rd, v.ra, v.rb, v.imm);
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk($sformatf("%s_ready_c%0d", name, k), instr_ready, 0);
            chk($sformatf("%s_done_c%0d", name, k), done, (k == 3));
            chk($sformatf("%s_we_c%0d", name, k), replaceEn, (k == 3));
        end
        chk({name, "_sel"}, replaceSel, v.rd);
        chk({name, "_data"}, replaceData, v.exp_data);
        chk({name, "_result"}, result, v.exp_data);
        chk({name, "_carry"}, carry, v.exp_c);
        chk({name, "_zero"}, zero, v.exp_z);
        @(negedge clk);
        chk({name, "_ready_c4"}, instr_ready, 1);
        chk({name, "_done_c4"}, done, 0);
    endtask

    function automatic vec_t mk(input logic [2:0] o, input logic [AW-1:0] d, input logic [AW-1:0] a,
                                input logic [AW-1:0] b, input logic [DW-1:0] im,
                                input logic [DW-1:0] ed, input logic ec, input logic ez);
        vec_t v;
        v.op = o; v.rd = d; v.ra = a; v.rb = b; v.imm = im;
        v.exp_data = ed; v.exp_c = ec; v.exp_z = ez;
        return v;
    endfunction

    initial begin
        int seen_done;
        vt[0]  = mk(OP_LDI, 4'd0,  4'd0, 4'd0, 8'hAA, 8'hAA, 1'b0, 1'b0);
        vt[1]  = mk(OP_LDI, 4'd1,  4'd0, 4'd0, 8'hBB, 8'hBB, 1'b0, 1'b0);
        vt[2]  = mk(OP_ADD, 4'd2,  4'd0, 4'd1, 8'h00, 8'h65, 1'b1, 1'b0);
        vt[3]  = mk(OP_SUB, 4'd3,  4'd1, 4'd0, 8'h00, 8'h11, 1'b0, 1'b0);
        vt[4]  = mk(OP_SUB, 4'd9,  4'd0, 4'd1, 8'h00, 8'hEF, 1'b1, 1'b0);
        vt[5]  = mk(OP_XOR, 4'd4,  4'd0, 4'd0, 8'h00, 8'h00, 1'b0, 1'b1);
        vt[6]  = mk(OP_SHL, 4'd10, 4'd0, 4'd0, 8'h00, 8'h54, 1'b1, 1'b0);
        vt[7]  = mk(OP_AND, 4'd11, 4'd0, 4'd1, 8'h00, 8'hAA, 1'b0, 1'b0);
        vt[8]  = mk(OP_OR,  4'd12, 4'd0, 4'd1, 8'h00, 8'hBB, 1'b0, 1'b0);
        vt[9]  = mk(OP_MOV, 4'd13, 4'd2, 4'd0, 8'h00, 8'h65, 1'b0, 1'b0);
        vt[10] = mk(OP_SUB, 4'd15, 4'd1, 4'd1, 8'h00, 8'h00, 1'b0, 1'b1);
        vt[11] = mk(OP_LDI, 4'd7,  4'd0, 4'd0, 8'h77, 8'h77, 1'b0, 1'b0);
        vt[12] = mk(OP_ADD, 4'd14, 4'd1, 4'd1, 8'h00, 8'h76, 1'b1, 1'b0);

        // Reset state
        rst = 1'b1; instr_valid = 1'b0;
        drive(3'd0, 4'd0, 4'd0, 4'd0, 8'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", instr_ready, 0);
        chk("rst_outs", {A_sel, B_sel, replaceSel, replaceData, replaceEn, done, result, carry, zero}, 0);
        rst = 1'b0;
        #1 chk("post_rst_ready", instr_ready, 1);

        for (int i = 0; i < NV; i++) run($sformatf("v%0d", i), vt[i]);

        // Back-to-back RAW with instr_valid held high
        wait_ready("b2b");
        drive(OP_LDI, 4'd5, 4'd0, 4'd0, 8'h0F);
        instr_valid = 1'b1;
        @(posedge clk);
        #1 drive(OP_ADD, 4'd6, 4'd5, 4'd5, 8'h00);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk($sformatf("b2b_ready_c%0d", k), instr_ready, (k == 4));
            if (k == 3) chk("b2b_ldi_data", {replaceEn, replaceSel, replaceData}, {1'b1, 4'd5, 8'h0F});
        end
        @(posedge clk);
        #1 instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("b2b_add_wb", {done, replaceEn, replaceSel, replaceData}, {1'b1, 1'b1, 4'd6, 8'h1E});

        // instr_valid pulsed while busy is ignored
        wait_ready("ign");
        drive(OP_MOV, 4'd8, 4'd0, 4'd0, 8'h00);
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            drive(OP_LDI, 4'd9, 4'd1, 4'd1, 8'h33);
            instr_valid = 1'b1;
            #1 chk($sformatf("ign_ready_c%0d", k), instr_ready, 0);
        end
        chk("ign_wb", {done, replaceSel, replaceData}, {1'b1, 4'd8, 8'hAA});
        instr_valid = 1'b0;
        seen_done = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        chk("ign_no_extra_done", seen_done, 0);
        chk("ign_hold", {replaceSel, replaceData}, {4'd8, 8'hAA});

        // Reset during EXEC of ADD rd=7
        wait_ready("rexec");
        drive(OP_ADD, 4'd7, 4'd0, 4'd1, 8'h00);
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1 chk("rexec_we_rstcyc", replaceEn, 0);
        @(negedge clk);
        chk("rexec_outs", {instr_ready, A_sel, B_sel, replaceSel, replaceData, replaceEn, done, result, carry, zero}, 0);
        rst = 1'b0;
        #1 chk("rexec_ready", instr_ready, 1);
        run("rexec_r7", mk(OP_MOV, 4'd8, 4'd7, 4'd0, 8'h00, 8'h77, 1'b0, 1'b0));

        // Reset landing in WB must suppress the write
        wait_ready("rwb");
        drive(OP_ADD, 4'd7, 4'd0, 4'd1, 8'h00);
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1 chk("rwb_we_done", {replaceEn, done}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        run("rwb_r7", mk(OP_MOV, 4'd8, 4'd7, 4'd0, 8'h00, 8'h77, 1'b0, 1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
